// File: rtl/ika87ad_irq_pkg.sv
// Shared definitions for the IKA87AD interrupt front end.
package ika87ad_irq_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_BOTH  = 2'b11
  } irq_mode_t;

endpackage

// File: rtl/ika87ad_irq_chan.sv
// One interrupt channel: noise filter, level/edge detection, sticky event latch and request flag.
module ika87ad_irq_chan
  import ika87ad_irq_pkg::*;
#(
  parameter int unsigned FILT_DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cnt_tick,
  input  logic       sample,
  input  logic       irq,
  input  logic       filt_en,
  input  logic [1:0] mode,
  input  logic       set_tick,
  input  logic       rst_tick,
  input  logic       clr,
  output logic       flag
);

  logic [FILT_DEPTH-1:0] shreg;
  logic [FILT_DEPTH-1:0] shreg_next;
  logic                  level;
  logic                  prev;
  logic                  evt;
  logic                  hit;
  logic                  set_cond;
  logic                  consume;
  irq_mode_t             md;

  assign md       = irq_mode_t'(mode);
  assign set_cond = ((md == MODE_LEVEL) && level) || evt;
  // A simultaneous clear tick blocks the set and leaves the event pending.
  assign consume  = set_tick && !rst_tick;

  always_comb begin
    shreg_next = {shreg[FILT_DEPTH-2:0], irq};
    hit        = 1'b0;
    if (cnt_tick) begin
      case (md)
        MODE_RISE: hit = level & ~prev;
        MODE_FALL: hit = ~level & prev;
        MODE_BOTH: hit = level ^ prev;
        default:   hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      if (filt_en && sample) begin
        shreg <= shreg_next;
        if (&shreg_next)
          level <= 1'b1;
        else if (~|shreg_next)
          level <= 1'b0;
      end else if (!filt_en && cnt_tick) begin
        level <= irq;
      end
      if (cnt_tick)
        prev <= level;
    end
  end

  // A new edge arriving in the consuming cycle is kept for the next set tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      evt <= 1'b0;
    else if (hit)
      evt <= 1'b1;
    else if (consume)
      evt <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag <= 1'b0;
    end else if (rst_tick) begin
      if (clr)
        flag <= 1'b0;
    end else if (set_tick && set_cond) begin
      flag <= 1'b1;
    end
  end

endmodule

// File: rtl/ika87ad_irq_array.sv
// IKA87AD interrupt array: shared prescaler, NCH channels, acknowledge decode and priority encoder.
module ika87ad_irq_array
  import ika87ad_irq_pkg::*;
#(
  parameter int unsigned NCH        = 8,
  parameter int unsigned FILT_DIV   = 36,
  parameter int unsigned FILT_DEPTH = 3,
  parameter int unsigned CW         = $clog2(NCH)
) (
  input  logic             i_EMUCLK,
  input  logic             i_MRST,
  input  logic             i_CNTTICK,
  input  logic             i_SETTICK,
  input  logic             i_RSTTICK,
  input  logic [NCH-1:0]   i_IRQ,
  input  logic [NCH-1:0]   i_FILT_EN,
  input  logic [2*NCH-1:0] i_MODE,
  input  logic [NCH-1:0]   i_MASK_n,
  input  logic             i_MANUAL_ACK,
  input  logic [CW-1:0]    i_ACK_CODE,
  input  logic             i_AUTO_ACK,
  output logic [NCH-1:0]   o_IFLAG,
  output logic             o_IRQ_PEND,
  output logic [CW-1:0]    o_IRQ_CODE
);

  localparam int unsigned   PW       = (FILT_DIV > 1) ? $clog2(FILT_DIV) : 1;
  localparam logic [PW-1:0] LAST     = PW'(FILT_DIV - 1);
  localparam logic [CW:0]   CODE_LIM = (CW + 1)'(NCH);

  logic [PW-1:0]  pcnt;
  logic           sample;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] masked;
  logic [CW-1:0]  enc;
  logic           found;

  assign sample = i_CNTTICK && (pcnt == LAST);

  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST)
      pcnt <= '0;
    else if (i_CNTTICK)
      pcnt <= sample ? '0 : pcnt + 1'b1;
  end

  always_comb begin
    clr = '0;
    if (i_MANUAL_ACK) begin
      if ({1'b0, i_ACK_CODE} < CODE_LIM)
        clr[i_ACK_CODE] = 1'b1;
    end else if (i_AUTO_ACK && o_IRQ_PEND) begin
      clr[o_IRQ_CODE] = 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    ika87ad_irq_chan #(
      .FILT_DEPTH(FILT_DEPTH)
    ) u_chan (
      .clk     (i_EMUCLK),
      .rst     (i_MRST),
      .cnt_tick(i_CNTTICK),
      .sample  (sample),
      .irq     (i_IRQ[g]),
      .filt_en (i_FILT_EN[g]),
      .mode    (i_MODE[2*g +: 2]),
      .set_tick(i_SETTICK),
      .rst_tick(i_RSTTICK),
      .clr     (clr[g]),
      .flag    (o_IFLAG[g])
    );
  end

  always_comb begin
    masked = o_IFLAG & i_MASK_n;
    enc    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (masked[i] && !found) begin
        enc   = CW'(i);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      o_IRQ_PEND <= 1'b0;
      o_IRQ_CODE <= '0;
    end else begin
      o_IRQ_PEND <= found;
      if (found)
        o_IRQ_CODE <= enc;
    end
  end

endmodule

// File: tb/tb_ika87ad_irq_array.sv
// Self-checking bench for ika87ad_irq_array: directed scenarios plus random traffic against a reference model.
module tb_ika87ad_irq_array;

  localparam int NCH        = 8;
  localparam int FILT_DIV   = 36;
  localparam int FILT_DEPTH = 3;
  localparam int CW         = 3;

  logic             clk        = 1'b0;
  logic             rst        = 1'b1;
  logic             cnt_tick   = 1'b0;
  logic             set_tick   = 1'b0;
  logic             rst_tick   = 1'b0;
  logic             manual_ack = 1'b0;
  logic             auto_ack   = 1'b0;
  logic [NCH-1:0]   irq        = '0;
  logic [NCH-1:0]   filt_en    = '0;
  logic [NCH-1:0]   mask_n     = '1;
  logic [2*NCH-1:0] mode       = '0;
  logic [CW-1:0]    ack_code   = '0;
  logic [NCH-1:0]   iflag;
  logic             pend;
  logic [CW-1:0]    code;

  always #5 clk = ~clk;

  ika87ad_irq_array #(
    .NCH(NCH),
    .FILT_DIV(FILT_DIV),
    .FILT_DEPTH(FILT_DEPTH)
  ) dut (
    .i_EMUCLK    (clk),
    .i_MRST      (rst),
    .i_CNTTICK   (cnt_tick),
    .i_SETTICK   (set_tick),
    .i_RSTTICK   (rst_tick),
    .i_IRQ       (irq),
    .i_FILT_EN   (filt_en),
    .i_MODE      (mode),
    .i_MASK_n    (mask_n),
    .i_MANUAL_ACK(manual_ack),
    .i_ACK_CODE  (ack_code),
    .i_AUTO_ACK  (auto_ack),
    .o_IFLAG     (iflag),
    .o_IRQ_PEND  (pend),
    .o_IRQ_CODE  (code)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: filter tracked as run length of the latest identical samples.
  bit m_level[NCH];
  bit m_prev[NCH];
  bit m_evt[NCH];
  bit m_flag[NCH];
  bit m_last[NCH];
  int m_run[NCH];
  int m_cnt;
  bit m_pend;
  int m_code;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_level[c] = 0; m_prev[c] = 0; m_evt[c] = 0; m_flag[c] = 0;
      m_last[c]  = 0; m_run[c]  = FILT_DEPTH;
    end
    m_cnt = 0; m_pend = 0; m_code = 0;
  endfunction

  function automatic logic [NCH-1:0] m_flags();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_flag[c];
    return v;
  endfunction

  function automatic void model_step();
    logic [NCH-1:0] clr;
    bit             sample;
    bit             any;
    int             first;
    int             md;
    bit             lv, pv, det, setc;
    clr    = '0;
    sample = cnt_tick && (m_cnt == FILT_DIV - 1);
    any    = 0;
    first  = 0;
    if (manual_ack) begin
      if (int'(ack_code) < NCH) clr[ack_code] = 1'b1;
    end else if (auto_ack && m_pend) begin
      clr[m_code] = 1'b1;
    end
    for (int c = NCH - 1; c >= 0; c--)
      if (m_flag[c] && mask_n[c]) begin any = 1; first = c; end
    for (int c = 0; c < NCH; c++) begin
      md   = int'(mode[2*c +: 2]);
      lv   = m_level[c];
      pv   = m_prev[c];
      det  = cnt_tick && ((md == 1 && lv && !pv) || (md == 2 && !lv && pv) || (md == 3 && lv != pv));
      setc = (md == 0 && lv) || m_evt[c];
      if (rst_tick) begin
        if (clr[c]) m_flag[c] = 0;
      end else if (set_tick && setc) begin
        m_flag[c] = 1;
      end
      if (set_tick && !rst_tick) m_evt[c] = 0;
      if (det) m_evt[c] = 1;
      if (cnt_tick) m_prev[c] = lv;
      if (filt_en[c]) begin
        if (sample) begin
          if (irq[c] == m_last[c]) m_run[c]++;
          else begin m_last[c] = irq[c]; m_run[c] = 1; end
          if (m_run[c] >= FILT_DEPTH) m_level[c] = m_last[c];
        end
      end else if (cnt_tick) begin
        m_level[c] = irq[c];
      end
    end
    m_pend = any;
    if (any) m_code = first;
    if (cnt_tick) m_cnt = (m_cnt == FILT_DIV - 1) ? 0 : m_cnt + 1;
  endfunction

  task automatic check_outputs();
    check_eq("iflag", 32'(iflag), 32'(m_flags()));
    check_eq("pend", 32'(pend), 32'(m_pend));
    check_eq("code", 32'(code), 32'(m_code));
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
      check_outputs();
    end
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  task automatic align();
    int guard;
    guard = 0;
    while (m_cnt != 0 && guard < 2 * FILT_DIV) begin
      tick(1);
      guard++;
    end
  endtask

  task automatic pulse_set();
    set_tick = 1'b1; tick(1); set_tick = 1'b0;
  endtask

  task automatic manual_clear(input logic [CW-1:0] ch);
    manual_ack = 1'b1; ack_code = ch; rst_tick = 1'b1;
    tick(1);
    rst_tick = 1'b0; manual_ack = 1'b0;
  endtask

  initial begin
    model_reset();
    tick(3);
    check_eq("rst_iflag", 32'(iflag), 32'h0);
    check_eq("rst_pend", 32'(pend), 32'h0);
    check_eq("rst_code", 32'(code), 32'h0);
    rst = 1'b0;
    cnt_tick = 1'b1;

    // Filter on ch0, rising edge
    set_mode(0, 2'b01);
    filt_en = 8'h01;
    align();
    irq[0] = 1'b1; tick(FILT_DIV); irq[0] = 1'b0;
    tick(3 * FILT_DIV);
    pulse_set();
    check_eq("glitch_flag", 32'(iflag), 32'h0);
    align();
    irq[0] = 1'b1; tick(3 * FILT_DIV); tick(2);
    pulse_set();
    check_eq("filt_flag", 32'(iflag), 32'h01);
    tick(1);
    check_eq("filt_pend", 32'(pend), 32'h1);
    check_eq("filt_code", 32'(code), 32'h0);
    manual_clear(3'd0);
    check_eq("filt_clear", 32'(iflag), 32'h0);

    // Priority and masking
    filt_en = '0; mode = '0; irq = 8'h24;
    tick(2);
    pulse_set();
    irq = '0;
    tick(2);
    check_eq("prio_flags", 32'(iflag), 32'h24);
    mask_n = 8'hFB; tick(2);
    check_eq("prio_masked", 32'(code), 32'h5);
    mask_n = 8'hFF; tick(1);
    check_eq("prio_unmask", 32'(code), 32'h2);

    // Manual acknowledge
    manual_clear(3'd5);
    check_eq("mack_5", 32'(iflag), 32'h04);
    manual_clear(3'd7);
    check_eq("mack_7", 32'(iflag), 32'h04);
    manual_clear(3'd2);
    check_eq("mack_2", 32'(iflag), 32'h0);

    // Set/clear collision and auto acknowledge on ch3, falling, unfiltered
    set_mode(3, 2'b10);
    irq[3] = 1'b1; tick(3); irq[3] = 1'b0; tick(3);
    set_tick = 1'b1; rst_tick = 1'b1; tick(1); rst_tick = 1'b0;
    check_eq("collide", 32'(iflag[3]), 32'h0);
    tick(1); set_tick = 1'b0;
    check_eq("retained_evt", 32'(iflag[3]), 32'h1);
    tick(2);
    check_eq("auto_code", 32'(code), 32'h3);
    auto_ack = 1'b1; rst_tick = 1'b1; tick(1); rst_tick = 1'b0; auto_ack = 1'b0;
    check_eq("auto_ack", 32'(iflag), 32'h0);

    // Level mode re-set on ch1
    irq[1] = 1'b1; tick(2);
    pulse_set();
    check_eq("lvl_set", 32'(iflag[1]), 32'h1);
    manual_clear(3'd1);
    check_eq("lvl_ack", 32'(iflag[1]), 32'h0);
    pulse_set();
    check_eq("lvl_reset", 32'(iflag[1]), 32'h1);
    irq[1] = 1'b0; tick(2);
    manual_clear(3'd1);
    pulse_set();
    check_eq("lvl_low", 32'(iflag[1]), 32'h0);

    // Random traffic
    repeat (3000) begin
      cnt_tick   = ($urandom_range(0, 99) < 70);
      set_tick   = ($urandom_range(0, 99) < 25);
      rst_tick   = ($urandom_range(0, 99) < 12);
      manual_ack = $urandom_range(0, 1) == 1;
      auto_ack   = $urandom_range(0, 1) == 1;
      ack_code   = CW'($urandom_range(0, NCH - 1));
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 99) < 5) irq[c] = ~irq[c];
      if ($urandom_range(0, 99) < 2) mode = 16'($urandom);
      if ($urandom_range(0, 99) < 2) filt_en = 8'($urandom);
      if ($urandom_range(0, 99) < 5) mask_n = 8'($urandom);
      tick(1);
    end

    // Asynchronous reset mid-filter with all flags set
    cnt_tick = 1'b1; set_tick = 1'b0; rst_tick = 1'b0;
    manual_ack = 1'b0; auto_ack = 1'b0;
    mode = '0; filt_en = '0; irq = '1; mask_n = 8'hF0;
    tick(2);
    pulse_set();
    tick(1);
    check_eq("pre_rst_flags", 32'(iflag), 32'hFF);
    check_eq("pre_rst_code", 32'(code), 32'h4);
    filt_en = 8'hF0; irq = 8'h3C;
    tick(50);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_iflag", 32'(iflag), 32'h0);
    check_eq("arst_pend", 32'(pend), 32'h0);
    check_eq("arst_code", 32'(code), 32'h0);
    model_reset();
    tick(2);
    rst = 1'b0;
    irq = 8'hFF; mask_n = 8'hFF;
    repeat (150) begin
      set_tick = ($urandom_range(0, 99) < 30);
      tick(1);
    end
    set_tick = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
